// File: rtl/jtkunio_scroll_gen.sv
// jtkunio_scroll_gen: 16x16 tile-map scroll layer with CPU-visible VRAM and handshaked ROM fetch.
// Optional macro JTKUNIO_SCR_VSCROLL_EN adds scry to the vertical map row.
module jtkunio_scroll_gen #(
    parameter int unsigned MAPCW   = 6,
    parameter int unsigned MAPRW   = 4,
    parameter int unsigned CODEW   = 11,
    parameter int unsigned PALW    = 3,
    parameter int unsigned BPP     = 3,
    parameter int unsigned HOFFSET = 23,
    parameter int unsigned HTOTAL  = 384
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pxl_cen_i,
    input  logic                   flip_i,
    input  logic [8:0]             h_i,
    input  logic [7:0]             v_i,
    input  logic [MAPCW+3:0]       scrx_i,
    input  logic [MAPRW+3:0]       scry_i,
    input  logic [MAPCW+MAPRW:0]   cpu_addr_i,
    input  logic                   scr_cs_i,
    input  logic                   cpu_wrn_i,
    input  logic [7:0]             cpu_dout_i,
    output logic [7:0]             cpu_din_o,
    output logic [CODEW+4:0]       rom_addr_o,
    output logic                   rom_cs_o,
    input  logic [31:0]            rom_data_i,
    input  logic                   rom_ok_i,
    output logic [PALW+BPP-1:0]    pxl_o,
    output logic                   miss_o
);
    localparam int unsigned AW    = MAPCW + MAPRW + 1;
    localparam int unsigned ROMW  = CODEW + 5;
    localparam int unsigned HSW   = MAPCW + 4;
    localparam int unsigned VRW   = MAPRW + 4;
    localparam int unsigned EAW   = MAPCW + MAPRW;
    localparam int unsigned DEPTH = 1 << EAW;

    typedef enum logic [1:0] {ST_IDLE, ST_MAP, ST_ROM, ST_DONE} state_t;

    logic [9:0]          hraw, hwrap;
    logic [8:0]          hadv;
    logic [HSW-1:0]      hsum;
    logic [VRW-1:0]      vrow;
    logic [EAW-1:0]      scan_addr;
    logic [EAW-1:0]      cpu_idx;
    logic                cpu_hi, cpu_we;
    logic                grp_start, grp_end;
    logic [BPP-1:0]      colour;
    logic                unused_ok;

    logic [7:0]          vram_lo [DEPTH];
    logic [7:0]          vram_hi [DEPTH];
    logic [15:0]         rd_q;
    logic [7:0]          cpu_din_q;

    state_t              st_q;
    logic                rom_cs_q, miss_q, half_q;
    logic [3:0]          row_q;
    logic [ROMW-1:0]     rom_addr_q;
    logic [PALW-1:0]     pal_buf_q, cur_pal_q;
    logic [31:0]         buf_q, shift_q;
    logic [PALW+BPP-1:0] pxl_q;

    // Scan position: fetch-lead horizontal position plus scroll, wrapping at the map edges
    always_comb begin
        hraw  = 10'(h_i) + 10'(HOFFSET);
        hwrap = (hraw >= 10'(HTOTAL)) ? hraw - 10'(HTOTAL) : hraw;
        hadv  = hwrap[8:0] ^ {9{flip_i}};
        hsum  = HSW'(hadv) + scrx_i;
`ifdef JTKUNIO_SCR_VSCROLL_EN
        vrow  = VRW'(v_i) + scry_i;
`else
        vrow  = VRW'(v_i);
`endif
    end

    assign scan_addr = {vrow[VRW-1:4], hsum[HSW-1:4]};
    assign cpu_idx   = cpu_addr_i[EAW-1:0];
    assign cpu_hi    = cpu_addr_i[AW-1];
    assign cpu_we    = scr_cs_i & ~cpu_wrn_i;
    assign grp_start = (hsum[2:0] == 3'd0);
    assign grp_end   = (hsum[2:0] == 3'd7);
    assign colour    = flip_i ? shift_q[28 +: BPP] : shift_q[0 +: BPP];
    assign unused_ok = ^{hwrap[9], rd_q, scry_i};

    // Tile VRAM: byte-wide CPU port and 16-bit scan port; a same-cycle write is not seen by the scan read
    always_ff @(posedge clk) begin
        if (cpu_we) begin
            if (cpu_hi) vram_hi[cpu_idx] <= cpu_dout_i;
            else        vram_lo[cpu_idx] <= cpu_dout_i;
        end
        rd_q      <= {vram_hi[scan_addr], vram_lo[scan_addr]};
        cpu_din_q <= cpu_hi ? vram_hi[cpu_idx] : vram_lo[cpu_idx];
    end

    // Fetch FSM, pixel shifter and output pipeline; a group load always wins over a pending fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= ST_IDLE;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            miss_q     <= 1'b0;
            half_q     <= 1'b0;
            row_q      <= 4'd0;
            pal_buf_q  <= '0;
            cur_pal_q  <= '0;
            buf_q      <= 32'd0;
            shift_q    <= 32'd0;
            pxl_q      <= '0;
        end else begin
            miss_q <= 1'b0;
            case (st_q)
                ST_MAP: begin
                    rom_addr_q <= {rd_q[CODEW-1:0], half_q, row_q};
                    pal_buf_q  <= rd_q[15 -: PALW];
                    rom_cs_q   <= 1'b1;
                    st_q       <= ST_ROM;
                end
                ST_ROM: if (rom_ok_i) begin
                    buf_q    <= rom_data_i;
                    rom_cs_q <= 1'b0;
                    st_q     <= ST_DONE;
                end
                default: ;
            endcase
            if (pxl_cen_i) begin
                pxl_q <= (colour == '0) ? '0 : {cur_pal_q, colour};
                if (grp_end) begin
                    st_q     <= ST_IDLE;
                    rom_cs_q <= 1'b0;
                    if (st_q == ST_DONE) begin
                        shift_q   <= buf_q;
                        cur_pal_q <= pal_buf_q;
                    end else begin
                        shift_q <= 32'd0;
                        miss_q  <= (st_q == ST_MAP) || (st_q == ST_ROM);
                    end
                end else begin
                    shift_q <= flip_i ? {shift_q[27:0], 4'd0} : {4'd0, shift_q[31:4]};
                    if (grp_start && st_q == ST_IDLE) begin
                        st_q   <= ST_MAP;
                        half_q <= hsum[3];
                        row_q  <= vrow[3:0];
                    end
                end
            end
        end
    end

    assign cpu_din_o  = cpu_din_q;
    assign rom_addr_o = rom_addr_q;
    assign rom_cs_o   = rom_cs_q;
    assign pxl_o      = pxl_q;
    assign miss_o     = miss_q;

endmodule

// File: tb/tb_jtkunio_scroll_gen.sv
// tb_jtkunio_scroll_gen: randomized scroll-layer bench against a per-group pixel model with a ROM responder.
module tb_jtkunio_scroll_gen;
    localparam int unsigned MAPCW = 6, MAPRW = 4, CODEW = 11, PALW = 3, BPP = 3;
    localparam int unsigned HOFFSET = 23, HTOTAL = 384;
    localparam int unsigned AW = MAPCW + MAPRW + 1, EAW = AW - 1, ROMW = CODEW + 5;
    localparam int unsigned HSW = MAPCW + 4, VRW = MAPRW + 4, NENT = 1 << EAW;

    logic                clk = 1'b0, rst_n = 1'b0, pxl_cen = 1'b0, flip = 1'b0;
    logic [8:0]          h = 9'd0;
    logic [7:0]          v = 8'd0;
    logic [HSW-1:0]      scrx = '0;
    logic [VRW-1:0]      scry = '0;
    logic [AW-1:0]       cpu_addr = '0;
    logic                scr_cs = 1'b0, cpu_wrn = 1'b1;
    logic [7:0]          cpu_dout = 8'd0;
    logic [7:0]          cpu_din;
    logic [ROMW-1:0]     rom_addr;
    logic                rom_cs, miss;
    logic [31:0]         rom_data = 32'd0;
    logic                rom_ok = 1'b0;
    logic [PALW+BPP-1:0] pxl;

    jtkunio_scroll_gen dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen_i(pxl_cen), .flip_i(flip), .h_i(h), .v_i(v),
        .scrx_i(scrx), .scry_i(scry), .cpu_addr_i(cpu_addr), .scr_cs_i(scr_cs), .cpu_wrn_i(cpu_wrn),
        .cpu_dout_i(cpu_dout), .cpu_din_o(cpu_din), .rom_addr_o(rom_addr), .rom_cs_o(rom_cs),
        .rom_data_i(rom_data), .rom_ok_i(rom_ok), .pxl_o(pxl), .miss_o(miss)
    );

    always #5 clk = ~clk;

    logic [15:0]     vram_m [NENT];
    int              total = 0, bad = 0;
    int              expq [$];
    bit              rom_fixed_en = 1'b0;
    logic [31:0]     rom_fixed = 32'd0, salt = 32'd0;
    int              lat = 0, wh_rate = 0, cnt = 0;
    bit              busy = 1'b0, withhold = 1'b0, grp_pend = 1'b0, pend_wh = 1'b0;
    logic [ROMW-1:0] exp_addr = '0;

    function automatic logic [31:0] rom_fn(input logic [ROMW-1:0] a);
        if (rom_fixed_en) return rom_fixed;
        return (32'(a) * 32'h9E3779B1) ^ salt;
    endfunction

    // Screen position -> map pixel column, straight from the arithmetic definition
    function automatic int hsum_of(input int hh, input bit fl, input int sx);
        int ha;
        ha = (hh + int'(HOFFSET)) % int'(HTOTAL);
        if (fl) ha = 511 - ha;
        return (ha + sx) % (1 << HSW);
    endfunction

    function automatic int vrow_now();
`ifdef JTKUNIO_SCR_VSCROLL_EN
        return (int'(v) + int'(scry)) % (1 << VRW);
`else
        return int'(v) % (1 << VRW);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample after the edge, check miss, then act as the ROM for the next edge
    task automatic tick(input bit exp_miss);
        @(posedge clk); #1;
        chk("miss", 32'(miss), 32'(exp_miss));
        rom_ok = 1'b0;
        if (rom_cs) begin
            if (!busy) begin
                busy = 1'b1;
                cnt  = lat;
                chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
            end else if (cnt > 0) cnt--;
            if (cnt == 0 && !withhold) begin
                rom_ok   = 1'b1;
                rom_data = rom_fn(rom_addr);
            end
        end else busy = 1'b0;
    endtask

    // One pixel period (4 clocks): model the group fetched at s%8==0, expect its pixels one group later
    task automatic pix_step();
        int s, vr, ent, code, pal, nib, col;
        logic [31:0] data;
        bit em;
        s  = hsum_of(int'(h), flip, int'(scrx));
        em = (s % 8 == 7) && grp_pend && pend_wh;
        pxl_cen = 1'b1;
        tick(em);
        pxl_cen = 1'b0;
        if (s % 8 == 7) grp_pend = 1'b0;
        if (s % 8 == 0) begin
            vr       = vrow_now();
            ent      = int'(vram_m[(vr / 16) * (1 << MAPCW) + s / 16]);
            code     = ent % (1 << CODEW);
            pal      = ent >> (16 - PALW);
            exp_addr = ROMW'(code * 32 + ((s / 8) % 2) * 16 + vr % 16);
            withhold = (wh_rate != 0) && ($urandom_range(0, wh_rate - 1) == 0);
            data     = withhold ? 32'd0 : rom_fn(exp_addr);
            for (int i = 0; i < 8; i++) begin
                nib = flip ? int'((data >> (4 * (7 - i))) & 32'hF) : int'((data >> (4 * i)) & 32'hF);
                col = nib % (1 << BPP);
                expq.push_back(col == 0 ? 0 : pal * (1 << BPP) + col);
            end
            grp_pend = 1'b1;
            pend_wh  = withhold;
        end
        if (expq.size() > 8) chk("pxl", 32'(pxl), 32'(expq.pop_front()));
        repeat (3) tick(1'b0);
        if (flip) h = (h == 9'd0) ? 9'(HTOTAL - 1) : h - 9'd1;
        else      h = (h == 9'(HTOTAL - 1)) ? 9'd0 : h + 9'd1;
    endtask

    task automatic run_scn(input bit fl, input int sx, input int vv, input int lt, input int wr, input int ncen);
        rst_n = 1'b0; pxl_cen = 1'b0; rom_ok = 1'b0; busy = 1'b0;
        expq.delete(); grp_pend = 1'b0; pend_wh = 1'b0;
        flip = fl; scrx = HSW'(sx); v = 8'(vv); lat = lt; wh_rate = wr;
        h = fl ? 9'(HTOTAL - 1) : 9'd0;
        @(posedge clk); #1;
        chk("rst_pxl", 32'(pxl), 32'd0);
        chk("rst_rom_cs", 32'(rom_cs), 32'd0);
        chk("rst_miss", 32'(miss), 32'd0);
        rst_n = 1'b1;
        repeat (ncen) pix_step();
    endtask

    task automatic cpu_wr(input int idx, input bit hi, input logic [7:0] d);
        cpu_addr = {hi, EAW'(idx)};
        cpu_dout = d; scr_cs = 1'b1; cpu_wrn = 1'b0;
        @(posedge clk); #1;
        scr_cs = 1'b0; cpu_wrn = 1'b1;
        if (hi) vram_m[idx][15:8] = d;
        else    vram_m[idx][7:0]  = d;
    endtask

    initial begin
        bit found;
        int idx;
        bit hi;
        salt = $urandom;
        scry = VRW'($urandom);
        // VRAM fill through the CPU port, then byte read-back
        for (int i = 0; i < int'(NENT); i++) begin
            cpu_wr(i, 1'b0, 8'($urandom));
            cpu_wr(i, 1'b1, 8'($urandom));
        end
        cpu_wr(0, 1'b0, 8'h05);
        cpu_wr(0, 1'b1, 8'h20);
        for (int i = 0; i < 8; i++) begin
            idx = (i == 0) ? 0 : int'($urandom_range(0, NENT - 1));
            hi  = 1'(i % 2);
            cpu_addr = {hi, EAW'(idx)}; scr_cs = 1'b1;
            @(posedge clk); #1;
            scr_cs = 1'b0;
            chk("cpu_din", 32'(cpu_din), hi ? 32'(vram_m[idx][15:8]) : 32'(vram_m[idx][7:0]));
        end

        // Entry 0x2005 at map (0,0): code 5, palette 1, ROM answers 2 clocks after the request
        run_scn(1'b0, 0, 3, 2, 0, 400);

        // Reset asserted while a ROM request is outstanding
        run_scn(1'b0, 0, 40, 8, 0, 20);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            pix_step();
            found = rom_cs;
        end
        chk("rom_cs_seen", 32'(found), 32'd1);
        rst_n = 1'b0; #1;
        chk("async_rom_cs", 32'(rom_cs), 32'd0);
        chk("async_pxl", 32'(pxl), 32'd0);
        chk("async_miss", 32'(miss), 32'd0);
        @(posedge clk); #1;
        run_scn(1'b0, 0, 40, 3, 0, 60);

        // Random scroll, rows, latencies, with occasional withheld ROM data
        repeat (3) run_scn(1'b0, int'($urandom_range(0, (1 << HSW) - 1)), int'($urandom_range(0, 255)),
                           int'($urandom_range(0, 10)), 4, 400);

        // Flipped screen with a fixed ROM word: colours 7..1 then transparent
        rom_fixed_en = 1'b1; rom_fixed = 32'h76543210;
        run_scn(1'b1, int'($urandom_range(0, (1 << HSW) - 1)), int'($urandom_range(0, 255)), 1, 0, 200);
        rom_fixed_en = 1'b0;

        // Scroll near the map edge: wrap from the last column to column 0
        run_scn(1'b0, (1 << HSW) - 4, int'($urandom_range(0, 255)), 3, 0, 400);

        // Frequent misses followed by recovering groups, flipped
        run_scn(1'b1, int'($urandom_range(0, (1 << HSW) - 1)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 10)), 2, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
